convolution_3x3: RTL and testbench
==================================

CONVOLUTION_3X3 -- requirements
Module: convolution_3x3

Interface
REQ-001 Parameter HRES, default 1280, horizontal resolution in pixels.
REQ-002 Parameter VRES, default 720, vertical resolution in lines.
REQ-003 Derived constants: HWIDTH = $clog2(HRES) and VWIDTH = $clog2(VRES).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk_in  input  1  system clock; all state SHALL update on the rising edge.
REQ-006 rst_n_in  input  1  asynchronous active-low reset.
REQ-007 data_in  input  [2:0][15:0]  one RGB565 column of three vertical pixels: [0] top, [1] centre, [2] bottom.
REQ-008 hcount_in  input  HWIDTH  column index of data_in.
REQ-009 vcount_in  input  VWIDTH  centre-row index of data_in.
REQ-010 data_valid_in  input  1  data_in, hcount_in and vcount_in are valid this cycle.
REQ-011 kernel_in  input  [8:0][7:0]  signed coefficients, with index = 3*row + col, row 0 top, col 0 left.
REQ-012 shift_in  input  4  right-shift normalisation amount.
REQ-013 pixel_out  output  16  filtered RGB565 pixel.
REQ-014 hcount_out  output  HWIDTH  column index of pixel_out.
REQ-015 vcount_out  output  VWIDTH  row index of pixel_out.
REQ-016 data_valid_out  output  1  pixel_out, hcount_out and vcount_out are valid this cycle.

Function
REQ-017 The block SHALL hold a 3x3 window win[r][c] (c=0 leftmost); on each valid input it SHALL shift win[r][0]<=win[r][1], win[r][1]<=win[r][2], win[r][2]<=data_in[r].
REQ-018 Invalid cycles SHALL leave the window unchanged; there are no stalls and no backpressure.
REQ-019 Active kernel/shift SHALL be loaded from kernel_in/shift_in only on a valid input with hcount_in==0 and vcount_in==0, taking effect for that same input; at all other times they SHALL hold.
REQ-020 Each channel (R[15:11], G[10:5], B[4:0]) SHALL be zero-extended, multiplied by the signed coefficient, and the 9 products summed in signed 18-bit arithmetic.
REQ-021 The sum SHALL be arithmetically shifted right by the active shift and clamped to [0,31] for R/B and [0,63] for G.
REQ-022 Pipeline stages: window shift, products, sum, shift+clamp to output register; each stage takes 1 cycle.
REQ-023 An input valid at edge k SHALL yield data_valid_out=1 for exactly one cycle after edge k+3, with the result for the window containing that input.
REQ-024 hcount_out SHALL be hcount_in-1 (the window centre), and HRES-1 when hcount_in==0.
REQ-025 vcount_out SHALL equal vcount_in unchanged.
REQ-026 Count values SHALL travel in the pipeline alongside their data.
REQ-027 Back-to-back valid inputs SHALL produce back-to-back outputs; gaps in the input SHALL appear as identical gaps in the output.
REQ-028 Windows at the left border SHALL use whatever columns are held (no padding); this is accepted behaviour.

Reset
REQ-029 While rst_n_in=0: pixel_out=0, hcount_out=0, vcount_out=0, data_valid_out=0, window=0, all pipeline valid bits=0.
REQ-030 Reset SHALL set the active kernel to identity (index 4 = 1, others 0) and the active shift to 0.
REQ-031 Reset asserted mid-stream SHALL discard in-flight data; no data_valid_out SHALL appear until 4 cycles after the first valid input following deassertion.

Verification
REQ-032 Identity kernel, shift 0; stream an HRES-wide row with pixel=hcount -> pixel_out equals the previous column's input, hcount_out=hcount_in-1, latency 3.
REQ-033 At frame start load all-ones kernel, shift 3; feed constant 0x4208 (R=8,G=16,B=8) -> after 3 columns of fill, pixel_out=0x4A49 (R=9,G=18,B=9).
REQ-034 All-ones kernel, shift 3, constant 0xFFFF -> pixel_out=0xFFFF (clamped); centre coefficient -1 with all others 0 -> pixel_out=0x0000.
REQ-035 Change kernel_in mid-frame (hcount_in!=0) -> output unchanged until the next input with hcount_in==0 and vcount_in==0.
REQ-036 Valid pattern 1,0,1,1,0 -> data_valid_out shows the same pattern delayed 3 cycles; window is unchanged across gaps.
REQ-037 Assert rst_n_in with two results in flight -> outputs 0 immediately (asynchronously), no stale data_valid_out after release, kernel returns to identity.

Source files
------------

// File: rtl/convolution_3x3_if.sv
// Pixel stream bundle for the 3x3 convolution block: column input, kernel
// configuration and filtered pixel output.
interface convolution_3x3_if #(
  parameter int unsigned HRES = 1280,
  parameter int unsigned VRES = 720
);
  localparam int unsigned HWIDTH = $clog2(HRES);
  localparam int unsigned VWIDTH = $clog2(VRES);

  logic [2:0][15:0]   data_in;
  logic [HWIDTH-1:0]  hcount_in;
  logic [VWIDTH-1:0]  vcount_in;
  logic               data_valid_in;
  logic [8:0][7:0]    kernel_in;
  logic [3:0]         shift_in;
  logic [15:0]        pixel_out;
  logic [HWIDTH-1:0]  hcount_out;
  logic [VWIDTH-1:0]  vcount_out;
  logic               data_valid_out;

  // Source side: drives columns and configuration, observes results.
  modport master (
    output data_in, hcount_in, vcount_in, data_valid_in, kernel_in, shift_in,
    input  pixel_out, hcount_out, vcount_out, data_valid_out
  );

  // Filter side.
  modport slave (
    input  data_in, hcount_in, vcount_in, data_valid_in, kernel_in, shift_in,
    output pixel_out, hcount_out, vcount_out, data_valid_out
  );
endinterface

// File: rtl/convolution_3x3.sv
// 3x3 RGB565 convolution: window shift, products, sum, shift+clamp.
// Four registered stages; counts and shift amount travel with the data.
module convolution_3x3 #(
  parameter int unsigned HRES = 1280,
  parameter int unsigned VRES = 720
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  convolution_3x3_if.slave        io_conv
);

  localparam int unsigned HWIDTH = $clog2(HRES);
  localparam int unsigned VWIDTH = $clog2(VRES);
  localparam logic [HWIDTH-1:0] HLast = HWIDTH'(HRES - 1);
  localparam logic [8:0][7:0] KIdentity = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1,
                                           8'd0, 8'd0, 8'd0, 8'd0};

  // 18 bits hold the worst-case sum of nine 6-bit x signed 8-bit products.
  typedef logic signed [17:0] acc_t;

  logic               w_load;
  logic [5:0]         w_px [3][3][3];   // [channel][row][col], zero-extended
  acc_t               w_sum [3];
  acc_t               w_shifted [3];
  logic [4:0]         w_r;
  logic [5:0]         w_g;
  logic [4:0]         w_b;

  logic [15:0]        r_win [3][3];
  logic [8:0][7:0]    r_kernel;
  logic [3:0]         r_shift;
  acc_t               r_prod [3][9];
  acc_t               r_sum [3];
  logic [3:0]         r_sh1, r_sh2;
  logic               r_v0, r_v1, r_v2, r_vout;
  logic [HWIDTH-1:0]  r_h0, r_h1, r_h2, r_hout;
  logic [VWIDTH-1:0]  r_vc0, r_vc1, r_vc2, r_vcout;
  logic [15:0]        r_pixel;

  function automatic logic [4:0] sat5(input acc_t v);
    if (v < acc_t'(0))       return 5'd0;
    else if (v > acc_t'(31)) return 5'd31;
    else                     return 5'(v);
  endfunction

  function automatic logic [5:0] sat6(input acc_t v);
    if (v < acc_t'(0))       return 6'd0;
    else if (v > acc_t'(63)) return 6'd63;
    else                     return 6'(v);
  endfunction

  // Kernel/shift reload only on the first pixel of a frame.
  assign w_load = io_conv.data_valid_in && (io_conv.hcount_in == '0) &&
                  (io_conv.vcount_in == '0);

  // Active kernel and shift registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_kernel <= KIdentity;
      r_shift  <= '0;
    end else if (w_load) begin
      r_kernel <= io_conv.kernel_in;
      r_shift  <= io_conv.shift_in;
    end
  end

  // Stage 0: shift the window left and capture the centre-column counts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end
      r_h0  <= '0;
      r_vc0 <= '0;
    end else if (io_conv.data_valid_in) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
        r_win[r][2] <= io_conv.data_in[r];
      end
      r_h0  <= (io_conv.hcount_in == '0) ? HLast : io_conv.hcount_in - HWIDTH'(1);
      r_vc0 <= io_conv.vcount_in;
    end
  end

  // Split window pixels into zero-extended channels.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_px[0][r][c] = {1'b0, r_win[r][c][15:11]};
        w_px[1][r][c] = r_win[r][c][10:5];
        w_px[2][r][c] = {1'b0, r_win[r][c][4:0]};
      end
    end
  end

  // Stage 1: per-channel products; the kernel loaded with an input is already in r_kernel.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int i = 0; i < 9; i++) r_prod[ch][i] <= '0;
      end
      r_sh1 <= '0;
      r_h1  <= '0;
      r_vc1 <= '0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            r_prod[ch][3*r+c] <= acc_t'({12'b0, w_px[ch][r][c]}) *
                                 acc_t'($signed(r_kernel[3*r+c]));
          end
        end
      end
      r_sh1 <= r_shift;
      r_h1  <= r_h0;
      r_vc1 <= r_vc0;
    end
  end

  // Adder tree for each channel.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      w_sum[ch] = '0;
      for (int i = 0; i < 9; i++) w_sum[ch] = w_sum[ch] + r_prod[ch][i];
    end
  end

  // Stage 2: register the sums.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int ch = 0; ch < 3; ch++) r_sum[ch] <= '0;
      r_sh2 <= '0;
      r_h2  <= '0;
      r_vc2 <= '0;
    end else begin
      for (int ch = 0; ch < 3; ch++) r_sum[ch] <= w_sum[ch];
      r_sh2 <= r_sh1;
      r_h2  <= r_h1;
      r_vc2 <= r_vc1;
    end
  end

  // Normalise and saturate each channel to its field width.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) w_shifted[ch] = r_sum[ch] >>> r_sh2;
    w_r = sat5(w_shifted[0]);
    w_g = sat6(w_shifted[1]);
    w_b = sat5(w_shifted[2]);
  end

  // Stage 3: output register, updated only for valid results.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pixel <= '0;
      r_hout  <= '0;
      r_vcout <= '0;
    end else if (r_v2) begin
      r_pixel <= {w_r, w_g, w_b};
      r_hout  <= r_h2;
      r_vcout <= r_vc2;
    end
  end

  // Valid bits ride alongside the data so input gaps reappear at the output.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_vout <= 1'b0;
    end else begin
      r_v0   <= io_conv.data_valid_in;
      r_v1   <= r_v0;
      r_v2   <= r_v1;
      r_vout <= r_v2;
    end
  end

  assign io_conv.pixel_out      = r_pixel;
  assign io_conv.hcount_out     = r_hout;
  assign io_conv.vcount_out     = r_vcout;
  assign io_conv.data_valid_out = r_vout;

endmodule

// File: tb/tb_convolution_3x3.sv
// Bench for convolution_3x3: directed scenarios plus a random stream, each
// cycle compared with an arithmetic model of the filter.
module tb_convolution_3x3;

  localparam int unsigned HRES = 16;
  localparam int unsigned VRES = 4;
  localparam int unsigned HW   = $clog2(HRES);
  localparam int unsigned VW   = $clog2(VRES);

  typedef struct {
    bit          v;
    logic [15:0] pix;
    int          h;
    int          vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  convolution_3x3_if #(.HRES(HRES), .VRES(VRES)) conv_if ();

  convolution_3x3 #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .io_conv  (conv_if)
  );

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q[$];
  logic [15:0] mwin [3][3];
  int          mk [9];
  int          ms;
  logic [8:0][7:0] k_id, k_ones, k_neg, k_rnd;
  logic [2:0][15:0] col;
  int          hc, vc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mwin[r][c] = '0;
    for (int i = 0; i < 9; i++) mk[i] = (i == 4) ? 1 : 0;
    ms = 0;
  endtask

  // Direct evaluation of the filter over the model window.
  function automatic logic [15:0] model_pixel();
    int acc [3];
    int s, lim;
    int res [3];
    logic [15:0] p;
    acc = '{0, 0, 0};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p = mwin[r][c];
        acc[0] += int'(p[15:11]) * mk[3*r+c];
        acc[1] += int'(p[10:5])  * mk[3*r+c];
        acc[2] += int'(p[4:0])   * mk[3*r+c];
      end
    end
    for (int ch = 0; ch < 3; ch++) begin
      lim = (ch == 1) ? 63 : 31;
      s = acc[ch] >>> ms;
      if (s < 0) s = 0;
      if (s > lim) s = lim;
      res[ch] = s;
    end
    return {5'(res[0]), 6'(res[1]), 5'(res[2])};
  endfunction

  // One clock: drive inputs, advance the model, compare with the result due now.
  task automatic step(input bit valid, input logic [2:0][15:0] d, input int h, input int v,
                      input logic [8:0][7:0] k, input logic [3:0] s);
    exp_t e, ex;
    conv_if.data_valid_in = valid;
    conv_if.data_in       = d;
    conv_if.hcount_in     = HW'(h);
    conv_if.vcount_in     = VW'(v);
    conv_if.kernel_in     = k;
    conv_if.shift_in      = s;
    @(posedge clk);
    e = '{v: 1'b0, pix: 16'h0, h: 0, vc: 0};
    if (valid) begin
      if (h == 0 && v == 0) begin
        for (int i = 0; i < 9; i++) mk[i] = int'($signed(k[i]));
        ms = int'(s);
      end
      for (int r = 0; r < 3; r++) begin
        mwin[r][0] = mwin[r][1];
        mwin[r][1] = mwin[r][2];
        mwin[r][2] = d[r];
      end
      e = '{v: 1'b1, pix: model_pixel(), h: (h == 0) ? int'(HRES) - 1 : h - 1, vc: v};
    end
    q.push_back(e);
    #1;
    if (q.size() > 3) ex = q.pop_front();
    else ex = '{v: 1'b0, pix: 16'h0, h: 0, vc: 0};
    check("valid", 32'(conv_if.data_valid_out), 32'(ex.v));
    if (ex.v) begin
      check("pixel", 32'(conv_if.pixel_out), 32'(ex.pix));
      check("hcount", 32'(conv_if.hcount_out), 32'(ex.h));
      check("vcount", 32'(conv_if.vcount_out), 32'(ex.vc));
    end
  endtask

  task automatic idle(input int n);
    logic [2:0][15:0] junk;
    for (int i = 0; i < n; i++) begin
      junk = {16'($urandom), 16'($urandom), 16'($urandom)};
      step(1'b0, junk, 0, 0, k_ones, 4'd7);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pix"},   32'(conv_if.pixel_out), 32'h0);
    check({tag, "_h"},     32'(conv_if.hcount_out), 32'h0);
    check({tag, "_v"},     32'(conv_if.vcount_out), 32'h0);
    check({tag, "_valid"}, 32'(conv_if.data_valid_out), 32'h0);
  endtask

  function automatic logic [2:0][15:0] rnd_col();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  initial begin
    k_id   = '0;
    k_id[4] = 8'd1;
    for (int i = 0; i < 9; i++) k_ones[i] = 8'd1;
    k_neg  = '0;
    k_neg[4] = 8'hFF;
    conv_if.data_valid_in = 1'b0;
    conv_if.data_in       = '0;
    conv_if.hcount_in     = '0;
    conv_if.vcount_in     = '0;
    conv_if.kernel_in     = '0;
    conv_if.shift_in      = '0;
    model_reset();

    // Reset state.
    #1;
    check_zero_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Identity kernel from reset (row 1, no reload); centre pixel = hcount.
    for (int h = 0; h < int'(HRES); h++) begin
      col = {16'($urandom), 16'(h), 16'($urandom)};
      step(1'b1, col, h, 1, k_ones, 4'd3);
    end
    idle(3);

    // Frame start loads all-ones / shift 3 with constant 0x4208.
    for (int h = 0; h < 6; h++) step(1'b1, {3{16'h4208}}, h, 0, k_ones, 4'd3);
    idle(3);
    check("c4208", 32'(conv_if.pixel_out), 32'h4A49);

    // Saturation high, then negative centre coefficient saturating low.
    for (int h = 0; h < 4; h++) step(1'b1, {3{16'hFFFF}}, h, 0, k_ones, 4'd3);
    idle(3);
    check("sat_hi", 32'(conv_if.pixel_out), 32'hFFFF);
    for (int h = 0; h < 4; h++) step(1'b1, {3{16'hFFFF}}, h, 0, k_neg, 4'd0);
    idle(3);
    check("sat_lo", 32'(conv_if.pixel_out), 32'h0000);

    // Identity loaded at frame start; mid-frame kernel changes must be ignored.
    step(1'b1, rnd_col(), 0, 0, k_id, 4'd0);
    for (int h = 1; h < 9; h++) step(1'b1, rnd_col(), h, 0, k_ones, 4'd5);
    step(1'b1, {16'h1234, 16'h5678, 16'h9ABC}, 0, 1, k_ones, 4'd2);
    step(1'b1, {16'h0, 16'hBEEF, 16'h0}, 1, 1, k_ones, 4'd2);
    idle(3);
    check("hold_k", 32'(conv_if.pixel_out), 32'h5678);

    // Valid pattern 1,0,1,1,0.
    step(1'b1, rnd_col(), 2, 1, k_ones, 4'd0);
    step(1'b0, rnd_col(), 3, 1, k_ones, 4'd0);
    step(1'b1, rnd_col(), 3, 1, k_ones, 4'd0);
    step(1'b1, rnd_col(), 4, 1, k_ones, 4'd0);
    step(1'b0, rnd_col(), 5, 1, k_ones, 4'd0);
    idle(3);

    // Random stream with gaps and frame wraps (reloads at every frame start).
    hc = 0;
    vc = 0;
    for (int n = 0; n < 400; n++) begin
      bit vld;
      vld = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 9; i++) k_rnd[i] = 8'($signed($urandom_range(0, 12)) - 4);
      step(vld, rnd_col(), hc, vc, k_rnd, 4'($urandom_range(0, 4)));
      if (vld) begin
        hc = (hc + 1) % int'(HRES);
        if (hc == 0) vc = (vc + 1) % int'(VRES);
      end
    end
    idle(3);

    // Reset with two results in flight.
    step(1'b1, rnd_col(), 0, 0, k_ones, 4'd1);
    step(1'b1, rnd_col(), 1, 0, k_ones, 4'd1);
    conv_if.data_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(5);
    for (int h = 1; h < 6; h++) step(1'b1, rnd_col(), h, 2, k_ones, 4'd3);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
